seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Holds a 16-bit hex value and steps through the four digits. Drives one shared active-low segment bus and four active-low digit enables.
- Inserts a blanking gap between digits to suppress ghosting.
- New values load through a pulse/acknowledge pair and are applied only at frame boundaries, so a displayed frame never mixes old and new digits.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_hex_dec.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan controller.
// Hex glyph table is active-high ABCDEFG; inversion happens at the decoder.
package seg7_pkg;

  localparam int NDIG = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg7_hex_dec.sv
// Nibble + decimal point to active-low {A..G,Dp} pattern.
// Purely combinational; the caller registers the result.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~HEX_SEG[nib_i], ~dp_i};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller with blanking gap,
// frame-aligned value loading and leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [15:0] VALUE,
  input  logic [3:0]  DP_IN,
  input  logic        LZB,
  output logic        LOAD_ACK,
  output logic        FRAME,
  output logic [7:0]  SEG,
  output logic [3:0]  AN
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ON  = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          run_q, run_d;
  logic [15:0]   disp_q, disp_d;
  logic [3:0]    ddp_q, ddp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pdp_q, pdp_d;
  logic          pflag_q, pflag_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_q, frame_d;
  logic          ack_q, ack_d;

  logic          bnd;
  logic          on;
  logic          lz_blank;
  logic [3:0]    nib;
  logic          dp;
  logic [7:0]    dec_seg;

  seg7_hex_dec u_dec (
    .nib_i (nib),
    .dp_i  (dp),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    run_d   = run_q;
    disp_d  = disp_q;
    ddp_d   = ddp_q;
    pend_d  = pend_q;
    pdp_d   = pdp_q;
    pflag_d = pflag_q;
    frame_d = 1'b0;
    ack_d   = 1'b0;
    bnd     = 1'b0;

    if (!EN) begin
      cnt_d = '0;
      idx_d = '0;
      run_d = 1'b0;
    end else begin
      // first enabled edge restarts the frame like a wrap
      bnd   = !run_q || (cnt_q == CNT_MAX && idx_q == 2'd3);
      run_d = 1'b1;
      if (!run_q) begin
        cnt_d = '0;
        idx_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      frame_d = bnd;
    end

    if (bnd && LOAD) begin
      disp_d  = VALUE;
      ddp_d   = DP_IN;
      pflag_d = 1'b0;
      ack_d   = 1'b1;
    end else if (bnd && pflag_q) begin
      disp_d  = pend_q;
      ddp_d   = pdp_q;
      pflag_d = 1'b0;
      ack_d   = 1'b1;
    end else if (LOAD) begin
      pend_d  = VALUE;
      pdp_d   = DP_IN;
      pflag_d = 1'b1;
    end
  end

  always_comb begin
    on       = EN && (cnt_d >= CNT_ON);
    nib      = disp_d[{idx_d, 2'b00} +: 4];
    dp       = ddp_d[idx_d];
    lz_blank = LZB && (idx_d != 2'd0)
               && ((disp_d >> {idx_d, 2'b00}) == 16'h0);
    an_d     = on ? ~(4'b0001 << idx_d) : AN_OFF;
    seg_d    = (on && !lz_blank) ? dec_seg : SEG_OFF;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      run_q   <= 1'b0;
      disp_q  <= '0;
      ddp_q   <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      pflag_q <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      disp_q  <= disp_d;
      ddp_q   <= ddp_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      pflag_q <= pflag_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= frame_d;
      ack_q   <= ack_d;
    end
  end

  assign SEG      = seg_q;
  assign AN       = an_q;
  assign FRAME    = frame_q;
  assign LOAD_ACK = ack_q;

endmodule
